adq_seq_ctrl: RTL and testbench

//  Programmable acquisition sequencer for the ADC -> counter -> memory datapath.
//  On init it captures a burst of N samples: per sample it pulses start-of-conversion,

---
 rtl/adq_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_adq_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adq_seq_ctrl.sv
// Burst acquisition sequencer: START -> WAIT_EOC -> WRITE (-> GAP) per sample, DONE after N samples.
// Optional WAIT_EOC timeout with sticky err is enabled by defining ADQ_TIMEOUT_EN.
module adq_seq_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADD_S       = 8,
    parameter int unsigned GAP_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [ADD_S-1:0]  n_samples,
    input  logic [GAP_W-1:0]  gap,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sc,
    output logic              cs,
    output logic              mem_wr,
    output logic [ADD_S-1:0]  mem_add,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              ack,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_EOC,
        WRITE,
        GAP,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ADD_S-1:0] n_lat;
    logic [ADD_S-1:0] last_idx;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             timeout;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("adq_seq_ctrl: TIMEOUT_CYC must be at least 1");
    end

    // n=0 wraps to all-ones, which is exactly the 2**ADD_S-sample case
    assign last_idx = n_lat - ADD_S'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sc       = 1'b0;
        cs       = 1'b0;
        mem_wr   = 1'b0;
        busy     = 1'b1;
        ack      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (init) begin
                    state_nx = START;
                end
            end
            START: begin
                sc       = 1'b1;
                cs       = 1'b1;
                state_nx = WAIT_EOC;
            end
            WAIT_EOC: begin
                cs = 1'b1;
                if (eoc) begin
                    state_nx = WRITE;
                end else if (timeout) begin
                    state_nx = DONE;
                end
            end
            WRITE: begin
                mem_wr = 1'b1;
                if (mem_add == last_idx) begin
                    state_nx = DONE;
                end else if (gap_lat == '0) begin
                    state_nx = START;
                end else begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nx = START;
                end
            end
            DONE: begin
                ack      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_add <= '0;
            mem_din <= '0;
            n_lat   <= '0;
            gap_lat <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        n_lat   <= n_samples;
                        gap_lat <= gap;
                        mem_add <= '0;
                    end
                end
                WAIT_EOC: begin
                    if (eoc) begin
                        mem_din <= adc_data;
                    end
                end
                WRITE: begin
                    if (mem_add != last_idx) begin
                        mem_add <= mem_add + ADD_S'(1);
                        gap_cnt <= gap_lat;
                    end
                end
                GAP: gap_cnt <= gap_cnt - GAP_W'(1);
                default: ;
            endcase
        end
    end

`ifdef ADQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // to_cnt counts completed eoc-less WAIT_EOC cycles; the TIMEOUT_CYC-th one aborts
    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != WAIT_EOC) begin
                to_cnt <= '0;
            end else if (!eoc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == IDLE && init) begin
                err_q <= 1'b0;
            end else if (state == WAIT_EOC && !eoc && timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_adq_seq_ctrl.sv
// Self-checking bench for adq_seq_ctrl: a cycle-stepped ADC/stimulus driver records bus activity,
// each test compares it with the burst rules (address i, data of i-th conversion, gaps, ack).
module tb_adq_seq_ctrl;
    localparam int DATA_W      = 32;
    localparam int ADD_S       = 8;
    localparam int GAP_W       = 16;
    localparam int TIMEOUT_CYC = 64;

    logic              clk = 1'b0;
    logic              rst, init, eoc;
    logic [ADD_S-1:0]  n_samples;
    logic [GAP_W-1:0]  gap;
    logic [DATA_W-1:0] adc_data;
    logic              sc, cs, mem_wr, busy, ack, err;
    logic [ADD_S-1:0]  mem_add;
    logic [DATA_W-1:0] mem_din;

    int n_checks = 0;
    int n_fail   = 0;

    int                wr_add[$];
    logic [DATA_W-1:0] wr_din[$];
    int                wr_c[$];
    int                sc_c[$];
    int                ack_c[$];
    logic [DATA_W-1:0] exp_d[$];
    int                cs_bad;
    bit                err_seen, timed_out, aborted, busy_start, err_start, err_at_ack, err_end;
    logic [7:0]        snap;

    adq_seq_ctrl #(
        .DATA_W(DATA_W),
        .ADD_S(ADD_S),
        .GAP_W(GAP_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init(init),
        .n_samples(n_samples),
        .gap(gap),
        .eoc(eoc),
        .adc_data(adc_data),
        .sc(sc),
        .cs(cs),
        .mem_wr(mem_wr),
        .mem_add(mem_add),
        .mem_din(mem_din),
        .busy(busy),
        .ack(ack),
        .err(err)
    );

    always #5 clk = ~clk;

    // Starts a burst at the current negedge and steps one cycle per negedge until busy drops,
    // acting as the ADC (eoc mindly..maxdly cycles after sc) and logging what the DUT does.
    task automatic run_burst(input int n, input int gp, input int mindly, input int maxdly,
                             input bit noise, input bit ramp, input int abort_at, input int withhold_at);
        int cnt;
        bit fin;
        wr_add.delete(); wr_din.delete(); wr_c.delete(); sc_c.delete(); ack_c.delete(); exp_d.delete();
        cs_bad = 0; err_seen = 0; timed_out = 0; aborted = 0; err_at_ack = 0;
        init = 1'b1; n_samples = ADD_S'(n); gap = GAP_W'(gp); eoc = 1'b0;
        @(negedge clk);
        init = 1'b0; n_samples = ADD_S'($urandom); gap = GAP_W'($urandom_range(0, 7));
        busy_start = busy; err_start = err;
        cnt = 0; fin = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            if (!busy) begin
                fin = 1;
            end else begin
                if (mem_wr) begin
                    wr_add.push_back(int'(mem_add)); wr_din.push_back(mem_din); wr_c.push_back(c);
                end
                if (sc) sc_c.push_back(c);
                if ((mem_wr && cs) || (sc && !cs)) cs_bad++;
                if (err) err_seen = 1;
                if (ack) begin ack_c.push_back(c); err_at_ack = err; end
                if (abort_at >= 0 && sc_c.size() == abort_at + 1 && cs && !sc) begin
                    rst = 1'b1; eoc = 1'b0; aborted = 1; fin = 1;
                end else begin
                    eoc  = 1'b0;
                    init = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (sc) begin
                        cnt = (sc_c.size() - 1 == withhold_at) ? -1 : int'($urandom_range(mindly, maxdly));
                        if (noise) begin eoc = 1'b1; adc_data = $urandom; end
                    end else if (cnt > 0) begin
                        cnt--;
                        if (cnt == 0) begin
                            eoc = 1'b1;
                            adc_data = ramp ? DATA_W'(32'hFFFF_FFFF - exp_d.size()) : DATA_W'($urandom);
                            exp_d.push_back(adc_data);
                        end
                    end else if (noise && busy && !cs) begin
                        eoc = 1'($urandom_range(0, 1)); adc_data = $urandom;
                    end
                    @(negedge clk);
                end
            end
        end
        if (!fin) timed_out = 1;
        init = 1'b0; eoc = 1'b0;
        err_end = err;
        if (aborted) begin
            @(negedge clk);
            snap = {sc, cs, mem_wr, busy, ack, err, |mem_add, |mem_din};
            rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; init = 1'b1; eoc = 1'b1; n_samples = 8'd5; gap = '0; adc_data = '1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sc, cs, mem_wr, busy, ack, err} !== 6'b0 || mem_add !== '0 || mem_din !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sc/cs/wr/busy/ack/err=%b add=%0h din=%0h, required all 0",
                     {sc, cs, mem_wr, busy, ack, err}, mem_add, mem_din);
        end
        rst = 1'b0; init = 1'b0; eoc = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_basic();
        run_burst(4, 0, 3, 3, 0, 1, -1, -1);
        n_checks++;
        if (timed_out || busy_start !== 1'b1) begin
            n_fail++; $display("FAIL basic_run: timed_out=%0d busy_start=%b, required 0/1", timed_out, busy_start);
        end
        n_checks++;
        if (wr_add.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d writes, required 4", wr_add.size()); end
        for (int i = 0; i < wr_add.size(); i++) begin
            n_checks++;
            if (wr_add[i] != i || wr_din[i] !== DATA_W'(32'hFFFF_FFFF - i) || wr_c[i] - sc_c[i] != 4) begin
                n_fail++;
                $display("FAIL basic_write%0d: got add=%0d din=%0h lat=%0d, required add=%0d din=%0h lat=4",
                         i, wr_add[i], wr_din[i], wr_c[i] - sc_c[i], i, DATA_W'(32'hFFFF_FFFF - i));
            end
        end
        n_checks++;
        if (ack_c.size() != 1 || wr_c.size() != 4 || ack_c[0] != wr_c[3] + 1) begin
            n_fail++; $display("FAIL basic_ack: got %0d acks, required exactly 1 right after the last write", ack_c.size());
        end
    endtask

    task automatic test_full_depth();
        run_burst(0, 0, 1, 2, 0, 0, -1, -1);
        n_checks++;
        if (timed_out || wr_add.size() != 256) begin
            n_fail++; $display("FAIL full_count: got %0d writes (timed_out=%0d), required 256", wr_add.size(), timed_out);
        end
        for (int i = 0; i < wr_add.size(); i++) begin
            n_checks++;
            if (wr_add[i] != i || wr_din[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL full_write%0d: got add=%0d din=%0h, required add=%0d din=%0h", i, wr_add[i], wr_din[i], i, exp_d[i]);
            end
        end
        n_checks++;
        if (ack_c.size() != 1 || wr_c.size() != 256 || ack_c[0] != wr_c[255] + 1) begin
            n_fail++; $display("FAIL full_ack: got %0d acks, required exactly 1 after write 255", ack_c.size());
        end
    endtask

    task automatic test_gap();
        run_burst(3, 5, 1, 4, 0, 0, -1, -1);
        n_checks++;
        if (timed_out || wr_add.size() != 3 || sc_c.size() != 3) begin
            n_fail++; $display("FAIL gap_count: got %0d writes %0d sc, required 3/3", wr_add.size(), sc_c.size());
        end
        for (int i = 0; i + 1 < sc_c.size() && i < wr_c.size(); i++) begin
            n_checks++;
            if (sc_c[i + 1] - wr_c[i] - 1 != 5) begin
                n_fail++; $display("FAIL gap_spacing%0d: got %0d idle cycles, required 5", i, sc_c[i + 1] - wr_c[i] - 1);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        for (int r = 0; r < 3; r++) begin
            int n = int'($urandom_range(1, 10));
            run_burst(n, 2, 1, 3, 1, 0, -1, -1);
            n_checks++;
            if (timed_out || wr_add.size() != n || sc_c.size() != n || ack_c.size() != 1) begin
                n_fail++;
                $display("FAIL noise_count%0d: got %0d writes %0d sc %0d acks, required %0d/%0d/1",
                         r, wr_add.size(), sc_c.size(), ack_c.size(), n, n);
            end
            for (int i = 0; i < wr_add.size(); i++) begin
                n_checks++;
                if (wr_add[i] != i || wr_din[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL noise_write%0d_%0d: got add=%0d din=%0h, required add=%0d din=%0h",
                             r, i, wr_add[i], wr_din[i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        run_burst(8, 0, 2, 2, 0, 0, 2, -1);
        n_checks++;
        if (!aborted || wr_add.size() != 2) begin
            n_fail++; $display("FAIL midrst_writes: aborted=%0d got %0d writes, required 1/2", aborted, wr_add.size());
        end
        n_checks++;
        if (snap !== 8'h00) begin n_fail++; $display("FAIL midrst_outputs: got %b, required 00000000", snap); end
        run_burst(2, 0, 1, 1, 0, 0, -1, -1);
        n_checks++;
        if (wr_add.size() != 2 || wr_add[0] != 0 || wr_add[1] != 1) begin
            n_fail++; $display("FAIL midrst_restart: got %0d writes first add %0d, required 2 from add 0", wr_add.size(), wr_add[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int n  = int'($urandom_range(1, 12));
            int gp = int'($urandom_range(0, 4));
            bit ok = 1;
            run_burst(n, gp, 1, 4, 1'($urandom_range(0, 1)), 0, -1, -1);
            n_checks++;
            if (timed_out || busy_start !== 1'b1 || wr_add.size() != n || sc_c.size() != n
                || ack_c.size() != 1 || cs_bad != 0 || err_seen) begin
                n_fail++;
                $display("FAIL b2b_burst%0d: got busy0=%b writes=%0d sc=%0d acks=%0d cs_bad=%0d err=%0d, required 1/%0d/%0d/1/0/0",
                         r, busy_start, wr_add.size(), sc_c.size(), ack_c.size(), cs_bad, err_seen, n, n);
            end
            for (int i = 0; i < wr_add.size(); i++) begin
                if (wr_add[i] != i || wr_din[i] !== exp_d[i]) ok = 0;
                if (i + 1 < sc_c.size() && sc_c[i + 1] - wr_c[i] - 1 != gp) ok = 0;
            end
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL b2b_data%0d: got address/data/gap sequence wrong, required add 0..%0d gap %0d", r, n - 1, gp); end
        end
    endtask

`ifdef ADQ_TIMEOUT_EN
    task automatic test_timeout();
        run_burst(4, 0, 1, 3, 0, 0, -1, 2);
        n_checks++;
        if (wr_add.size() != 2 || sc_c.size() != 3 || ack_c.size() != 1) begin
            n_fail++; $display("FAIL to_counts: got %0d writes %0d sc %0d acks, required 2/3/1", wr_add.size(), sc_c.size(), ack_c.size());
        end
        n_checks++;
        if (ack_c.size() != 1 || sc_c.size() != 3 || ack_c[0] - sc_c[2] != TIMEOUT_CYC + 1) begin
            n_fail++; $display("FAIL to_latency: got %0d cycles sc->ack, required %0d", ack_c[0] - sc_c[2], TIMEOUT_CYC + 1);
        end
        n_checks++;
        if (err_at_ack !== 1'b1 || err_end !== 1'b1) begin
            n_fail++; $display("FAIL to_err: got err at ack=%b in idle=%b, required 1/1", err_at_ack, err_end);
        end
        run_burst(1, 0, 1, 1, 0, 0, -1, -1);
        n_checks++;
        if (err_start !== 1'b0 || err_at_ack !== 1'b0 || wr_add.size() != 1) begin
            n_fail++; $display("FAIL to_clear: got err=%b/%b writes=%0d, required 0/0/1", err_start, err_at_ack, wr_add.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_depth();
        test_gap();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
`ifdef ADQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
